// File: rtl/datapath_section1_ctrl_pkg.sv
// Shared opcode and FSM state constants for the a0 section sequencer.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package datapath_section1_ctrl_pkg;

  // Command opcodes carried on cmd_op
  localparam logic [1:0] OP_LOAD_IN   = 2'd0;
  localparam logic [1:0] OP_LOAD_REG  = 2'd1;
  localparam logic [1:0] OP_SUB_N     = 2'd2;
  localparam logic [1:0] OP_WRITEBACK = 2'd3;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Every op except WRITEBACK loads the a0 register while executing
  function automatic logic op_loads_a0(input logic [1:0] op);
    return op != OP_WRITEBACK;
  endfunction

endpackage

// File: rtl/datapath_section1_ctrl_if.sv
// Command handshake and datapath control bundle between control unit and a0 sequencer.
// Latency: n/a (wires only).
// Backpressure: cmd_valid is only honoured while cmd_ready=1; nothing is queued.
interface datapath_section1_ctrl_if #(
  parameter int COUNT_W = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [COUNT_W-1:0] cmd_count;
  logic               stop;
  logic               CTRL1;
  logic               CTRL2;
  logic               CTRL6;
  logic               CTRL7;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] writes;

  // Issuer of commands (top-level control unit)
  modport master (
    output cmd_valid, cmd_op, cmd_count, stop,
    input  cmd_ready, CTRL1, CTRL2, CTRL6, CTRL7, busy, done, writes
  );

  // The sequencer itself
  modport slave (
    input  cmd_valid, cmd_op, cmd_count, stop,
    output cmd_ready, CTRL1, CTRL2, CTRL6, CTRL7, busy, done, writes
  );
endinterface

// File: rtl/datapath_section1_ctrl_repeat_counter.sv
// Remaining-repeat down-counter plus saturating count of performed subtract writes.
// Latency: load/step take effect at the next rising edge; flags are combinational from state.
// Backpressure: none; the caller decides when to load or step.
module ctrl_repeat_counter #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_load_val,
  input  logic               i_step,
  output logic               o_last,
  output logic [COUNT_W-1:0] o_writes
);

  localparam logic [COUNT_W-1:0] ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [COUNT_W-1:0] r_rem;
  logic [COUNT_W-1:0] r_writes;

  // Load clears the write tally; each step burns one repeat and records one write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_writes <= '0;
    end else if (i_load) begin
      r_rem    <= i_load_val;
      r_writes <= '0;
    end else if (i_step) begin
      if (r_rem != '0) begin
        r_rem <= r_rem - ONE;
      end
      if (r_writes != '1) begin
        r_writes <= r_writes + ONE;
      end
    end
  end

  // Stepping now brings the remaining count to zero
  assign o_last   = (r_rem == ONE);
  assign o_writes = r_writes;

endmodule

// File: rtl/datapath_section1_ctrl.sv
// Command sequencer driving CTRL1/2/6/7 of the a0 datapath section, one command at a time.
// Latency: first EXEC cycle one edge after accept; done pulses the cycle after the last EXEC cycle.
// Backpressure: cmd_ready only in IDLE; commands offered while busy/done are dropped, not queued.
module datapath_section1_ctrl
  import datapath_section1_ctrl_pkg::*;
#(
  parameter int COUNT_W = 8
) (
  input logic                     CLK,
  input logic                     RST_N,
  datapath_section1_ctrl_if.slave bus
);

  logic [1:0]         r_state;
  logic [1:0]         r_op;

  logic               w_idle;
  logic               w_exec;
  logic               w_done;
  logic               w_accept;
  logic               w_sub;
  logic               w_last;
  logic [COUNT_W-1:0] w_writes;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_exec   = (r_state == ST_EXEC);
  assign w_done   = (r_state == ST_DONE);
  assign w_accept = w_idle && bus.cmd_valid;
  assign w_sub    = (r_op == OP_SUB_N);

  ctrl_repeat_counter #(
    .COUNT_W (COUNT_W)
  ) u_repeat (
    .clk        (CLK),
    .rst_n      (RST_N),
    .i_load     (w_accept),
    .i_load_val (bus.cmd_count),
    .i_step     (w_exec && w_sub),
    .o_last     (w_last),
    .o_writes   (w_writes)
  );

  // Sequencer: latch op on accept, run EXEC until the op's cycles are spent or stop, then pulse DONE
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD_IN;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_op <= bus.cmd_op;
            // A zero-length subtract has nothing to execute
            if ((bus.cmd_op == OP_SUB_N) && (bus.cmd_count == '0)) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // Single-cycle ops always finish; SUB_N finishes on its last repeat or on stop,
          // and the write in the stopping cycle has already been counted
          if (!w_sub || bus.stop || w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Moore decode: controls depend only on latched op and state, never on the cmd_* inputs
  assign bus.CTRL1     = w_exec && (r_op == OP_LOAD_REG);
  assign bus.CTRL2     = w_exec && w_sub;
  assign bus.CTRL6     = w_exec && (r_op == OP_WRITEBACK);
  assign bus.CTRL7     = w_exec && op_loads_a0(r_op);
  assign bus.busy      = w_exec;
  assign bus.cmd_ready = w_idle;
  assign bus.done      = w_done;
  // Write count is only meaningful alongside the done pulse
  assign bus.writes    = w_done ? w_writes : '0;

endmodule
